// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide issue controller.
package md_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MADD  = 4'd5,
      OP_MTHI  = 4'd6,
      OP_MTLO  = 4'd7,
      OP_MFHI  = 4'd8,
      OP_MFLO  = 4'd9
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } md_state_e;

   localparam int unsigned MD_TIMEOUT_DEF = 15;

endpackage

// File: rtl/md_watchdog.sv
// Watchdog counter for the RUN phase: held at zero while cleared, counts while
// enabled, and flags the cycle on which it would reach TIMEOUT.
module md_watchdog #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && (count_reg != CW'(TIMEOUT))) begin
         count_reg <= count_reg + CW'(1);
      end
   end

   // Fires on the TIMEOUT-th enabled cycle, i.e. the count reaches TIMEOUT at this edge.
   assign timeout = enable && (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/md_issue_ctrl.sv
// EX-stage issue controller for the multiply/divide unit: start pulses, HI/LO
// hazard stall, watchdog and stall counter. Optional macro: MD_DIV0_SKIP_EN.
module md_issue_ctrl
   import md_pkg::*;
#(
   parameter int unsigned TIMEOUT = MD_TIMEOUT_DEF,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   input  logic [3:0]       op_code,
   input  logic             ex_flush,
   input  logic             div_zero,
   input  logic             md_busy,
   output logic             md_mult,
   output logic             md_multu,
   output logic             md_div,
   output logic             md_divu,
   output logic             md_madd,
   output logic             md_mthi,
   output logic             md_mtlo,
   output logic             stall,
   output logic             div0,
   output logic             md_err,
   output logic [CNT_W-1:0] stall_cnt
);

   md_state_e        state_reg, state_next;
   logic             md_err_reg;
   logic             err_set;
   logic [CNT_W-1:0] stall_cnt_reg;
   logic             go;
   logic             is_md;
   logic             start;
   logic             timeout;

   assign go    = op_valid && !ex_flush;
   assign is_md = (op_code != 4'd0) && (op_code <= 4'd9);
   assign stall = go && is_md && (state_reg != ST_IDLE);

`ifndef MD_DIV0_SKIP_EN
   logic unused_div_zero;
   assign unused_div_zero = div_zero;
`endif

   md_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_reg != ST_RUN),
      .enable  (state_reg == ST_RUN),
      .timeout (timeout)
   );

   always_comb begin
      state_next = state_reg;
      err_set    = 1'b0;
      start      = 1'b0;
      md_mult    = 1'b0;
      md_multu   = 1'b0;
      md_div     = 1'b0;
      md_divu    = 1'b0;
      md_madd    = 1'b0;
      md_mthi    = 1'b0;
      md_mtlo    = 1'b0;
      div0       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (go) begin
               case (op_code)
                  OP_MULT:  begin md_mult  = 1'b1; start = 1'b1; end
                  OP_MULTU: begin md_multu = 1'b1; start = 1'b1; end
                  OP_MADD:  begin md_madd  = 1'b1; start = 1'b1; end
                  OP_MTHI:  md_mthi = 1'b1;
                  OP_MTLO:  md_mtlo = 1'b1;
`ifdef MD_DIV0_SKIP_EN
                  // A zero divisor is retired without touching the unit, so HI/LO keep their values.
                  OP_DIV: begin
                     if (div_zero) div0 = 1'b1;
                     else begin md_div = 1'b1; start = 1'b1; end
                  end
                  OP_DIVU: begin
                     if (div_zero) div0 = 1'b1;
                     else begin md_divu = 1'b1; start = 1'b1; end
                  end
`else
                  OP_DIV:   begin md_div  = 1'b1; start = 1'b1; end
                  OP_DIVU:  begin md_divu = 1'b1; start = 1'b1; end
`endif
                  default: ;
               endcase
            end
            if (start) state_next = ST_ARM;
         end
         ST_ARM: begin
            // The unit must have raised busy one cycle after the start pulse.
            if (md_busy) state_next = ST_RUN;
            else begin
               err_set    = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!md_busy) state_next = ST_IDLE;
            else if (timeout) begin
               err_set    = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         md_err_reg    <= 1'b0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (err_set) md_err_reg <= 1'b1;
         if (stall && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

   assign md_err    = md_err_reg;
   assign stall_cnt = stall_cnt_reg;

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Sequencing controller between the EX stage and the multiply/divide unit. Converts EX-stage MD instructions into one-cycle start/write pulses, holds the pipeline while a multi-cycle operation owns HI/LO, and releases it once results are committed. Also guards against a hung unit (watchdog) and counts stall cycles for performance analysis.

## Interface
- TIMEOUT, 15: max cycles in RUN before the watchdog fires (unit worst case is 11).
- CNT_W, 16: width of the stall-cycle counter.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  EX stage holds a valid instruction.
- op_code  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MTHI, 7 MTLO, 8 MFHI, 9 MFLO, 10–15 treated as NONE.
- ex_flush  in  1  EX instruction is killed this cycle (exception/interrupt).
- div_zero  in  1  EX divisor operand equals 0.
- md_busy  in  1  Busy from the MD unit.
- md_mult, md_multu, md_div, md_divu, md_madd, md_mthi, md_mtlo  out  1 each  one-cycle pulses to the MD unit.
- stall  out  1  freeze IF/ID/EX this cycle.
- div0  out  1  one-cycle pulse: divide by zero suppressed (feature-dependent).
- md_err  out  1  sticky watchdog error.
- stall_cnt  out  CNT_W  saturating count of cycles with stall=1.

## Operation
- States: IDLE, ARM, RUN.
- Define `go` = op_valid & !ex_flush. Start ops are 1–5. HI/LO ops are 6–9.
- IDLE:
  - go & start op → the matching pulse is asserted combinationally in the same cycle; next state ARM. The EX instruction retires (stall=0).
  - go & MTHI/MTLO → the matching pulse, stay in IDLE.
  - MFHI/MFLO → no pulse, no stall.
- ARM, exactly one cycle:
  - md_busy=1 → RUN.
  - md_busy=0 → set md_err, go to IDLE.
- RUN:
  - Watchdog counter clears on entry and increments each cycle.
  - md_busy=0 → IDLE.
  - Counter reaches TIMEOUT with md_busy still 1 → set md_err, go to IDLE.
- stall = go & (op_code in 1–9) & state≠IDLE. Non-MD instructions never stall.
- All pulses are 0 outside IDLE, and 0 whenever ex_flush=1.
- Flush during ARM/RUN does not abort the unit: the operation completes and the FSM proceeds normally.
- md_err clears only on reset.
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.

## Timing
- Reset values: state IDLE; all pulses 0; stall 0; div0 0; md_err 0; stall_cnt 0; watchdog counter 0.
- Start pulse in cycle N; ARM in cycle N+1; RUN from cycle N+2.
- Say md_busy falls at edge E. The unit writes HI/LO at that same edge E.
  - The controller samples md_busy=0 in the cycle after E, with stall still 1.
  - It returns to IDLE at the following edge.
  - A waiting MFHI/MFLO therefore reads committed HI/LO.
- MTHI followed immediately by MFHI needs no stall: the write lands at the edge between them.
- Reset asserted mid-operation returns the FSM to IDLE at once. The unit is reset by the same system reset.

## Configuration
- MD_DIV0_SKIP_EN defined:
  - In IDLE, go & (DIV or DIVU) & div_zero=1 issues no pulse and stays in IDLE.
  - div0 pulses for that one cycle, with no stall; HI/LO are unchanged.
- MD_DIV0_SKIP_EN undefined:
  - div_zero is ignored, div0 is tied to 0, and a zero divisor is issued normally.

## Structure
- Shared package md_pkg holds:
  - md_op_e (4-bit op encoding above);
  - md_state_e (IDLE/ARM/RUN);
  - MD_TIMEOUT_DEF=15.
- One sub-module, md_watchdog: loadable counter with clear, enable and a timeout compare, parameterised by TIMEOUT.

## Test plan
- MULT in IDLE, unit Busy for 6 cycles → md_mult pulses once at cycle 0; state ARM then RUN; a following MFLO stalls until the cycle after Busy falls, then reads lo=0x00000006 for operands 2×3.
- DIVU 7/2 immediately followed by MTHI → md_divu pulses once; MTHI stalls throughout; md_mthi pulses only after return to IDLE; final hi equals the MTHI data.
- MULT presented with ex_flush=1 → no pulse, state stays IDLE, stall=0.
- md_busy held at 1 for 20 cycles after a DIV → md_err=1 at RUN cycle 15, FSM in IDLE, stall released.
- DIV with div_zero=1:
  - MD_DIV0_SKIP_EN defined → div0=1 for 1 cycle, no md_div pulse.
  - MD_DIV0_SKIP_EN undefined → md_div pulses, div0=0.
- Reset asserted in RUN, plus stall_cnt saturation check with CNT_W=4 → after 16+ stalled cycles stall_cnt reads 4'hF; with reset low, all outputs zero immediately.
